// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - multi-cycle adder reusing a DIGIT-bit slice over WIDTH/DIGIT cycles
// Result registers are only written on the edge entering DONE, so they hold between operations.
module serial_adder_fsm #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("serial_adder_fsm: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] reg_a, reg_b, psum, psum_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             capture, step, last_step;

  logic [DIGIT-1:0] slice_a, slice_b, slice_s;
  logic             slice_c, slice_c_msb;

  assign slice_a = reg_a[DIGIT-1:0];
  assign slice_b = reg_b[DIGIT-1:0];
  assign {slice_c, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + {{DIGIT{1'b0}}, carry};

  // Carry into the slice MSB recovered from the MSB sum bit; feeds overflow on the last slice.
  assign slice_c_msb = slice_s[DIGIT-1] ^ slice_a[DIGIT-1] ^ slice_b[DIGIT-1];

  assign psum_next = (psum >> DIGIT) | (WIDTH'(slice_s) << (WIDTH - DIGIT));
  assign last_step = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        step = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_a    <= '0;
      reg_b    <= '0;
      psum     <= '0;
      carry    <= 1'b0;
      cnt      <= '0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else if (capture) begin
      reg_a <= a;
      reg_b <= b;
      carry <= c_in;
      cnt   <= '0;
    end else if (step) begin
      reg_a <= reg_a >> DIGIT;
      reg_b <= reg_b >> DIGIT;
      psum  <= psum_next;
      carry <= slice_c;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        sum      <= psum_next;
        c_out    <= slice_c;
        overflow <= slice_c ^ slice_c_msb;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb/tb_serial_adder_fsm.sv - scoreboard bench for serial_adder_fsm in three WIDTH/DIGIT configurations
module tb_serial_adder_fsm;

  typedef struct {
    int         cap;
    logic [7:0] s;
    logic       c;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       st0, st1, st2, ci0, ci1, ci2;
  logic [7:0] a0, b0, a2, b2;
  logic [3:0] a1, b1;
  logic       bz0, bz1, bz2, dn0, dn1, dn2, co0, co1, co2, ov0, ov1, ov2;
  logic [7:0] s0, s2;
  logic [3:0] s1;

  serial_adder_fsm #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .c_in(ci0),
    .busy(bz0), .done(dn0), .sum(s0), .c_out(co0), .overflow(ov0)
  );

  serial_adder_fsm #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .c_in(ci1),
    .busy(bz1), .done(dn1), .sum(s1), .c_out(co1), .overflow(ov1)
  );

  serial_adder_fsm #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst_n(rst_n), .start(st2), .a(a2), .b(b2), .c_in(ci2),
    .busy(bz2), .done(dn2), .sum(s2), .c_out(co2), .overflow(ov2)
  );

  int   cyc = 0;
  int   sel = 0;
  int   acc_edge = -1;
  int   kill_edge = -1;
  int   next_free = 0;
  bit   mon_en = 0;
  bit   accepted = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t cur;
  logic [7:0] hs = 8'h00;
  logic       hc = 1'b0;
  logic       hv = 1'b0;

  logic       v_busy, v_done, v_c, v_v;
  logic [7:0] v_sum;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    v_busy = bz0;
    v_done = dn0;
    v_sum  = s0;
    v_c    = co0;
    v_v    = ov0;
    if (sel == 1) begin
      v_busy = bz1;
      v_done = dn1;
      v_sum  = {4'h0, s1};
      v_c    = co1;
      v_v    = ov1;
    end else if (sel == 2) begin
      v_busy = bz2;
      v_done = dn2;
      v_sum  = s2;
      v_c    = co2;
      v_v    = ov2;
    end
  end

  function automatic void chk(string nm, logic [7:0] got, logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (dut %0d, edge %0d)", nm, got, want, sel, cyc);
    end
  endfunction

  // Reference: plain integer addition, overflow from operand/result sign bits.
  function automatic exp_t ref_add(int cap, int w, logic [7:0] av, logic [7:0] bv, logic cv);
    exp_t r;
    int   full;
    full  = int'(av) + int'(bv) + int'(cv);
    r.cap = cap;
    r.s   = 8'(full % (1 << w));
    r.c   = ((full >> w) & 1) != 0;
    r.v   = (av[w-1] == bv[w-1]) && (r.s[w-1] != av[w-1]);
    return r;
  endfunction

  // Monitor: expected busy/done from the accepted-edge bookkeeping, results from the queue.
  always @(negedge clk) begin
    if (mon_en) begin
      int  k, n;
      bit  live, eb, ed;
      k = cyc;
      n = (sel == 0) ? 8 : 2;
      if (k == kill_edge) begin
        hs = 8'h00;
        hc = 1'b0;
        hv = 1'b0;
      end
      live = (acc_edge >= 0) && !(kill_edge > acc_edge && k >= kill_edge);
      eb   = live && k >= acc_edge && k < acc_edge + n;
      ed   = live && k == acc_edge + n;
      chk("busy", {7'b0, v_busy}, {7'b0, eb});
      chk("done", {7'b0, v_done}, {7'b0, ed});
      if (v_done) begin
        while (q.size() > 0 && q[0].cap < kill_edge) void'(q.pop_front());
        if (q.size() == 0) begin
          chk("unexpected_done", 8'd1, 8'd0);
        end else begin
          cur = q.pop_front();
          chk("sum", v_sum, cur.s);
          chk("c_out", {7'b0, v_c}, {7'b0, cur.c});
          chk("overflow", {7'b0, v_v}, {7'b0, cur.v});
          hs = cur.s;
          hc = cur.c;
          hv = cur.v;
        end
      end else begin
        chk("sum_hold", v_sum, hs);
        chk("c_out_hold", {7'b0, v_c}, {7'b0, hc});
        chk("overflow_hold", {7'b0, v_v}, {7'b0, hv});
      end
    end
  end

  task automatic drive(input logic st, input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, input logic rv);
    int         e, w, n;
    logic [7:0] mask;
    @(posedge clk);
    #1;
    e    = cyc + 1;
    w    = (sel == 1) ? 4 : 8;
    n    = (sel == 0) ? 8 : 2;
    mask = (w == 4) ? 8'h0F : 8'hFF;
    av   = av & mask;
    bv   = bv & mask;
    st0  = 1'b0;
    st1  = 1'b0;
    st2  = 1'b0;
    case (sel)
      0: begin st0 = st; a0 = av; b0 = bv; ci0 = cv; end
      1: begin st1 = st; a1 = av[3:0]; b1 = bv[3:0]; ci1 = cv; end
      default: begin st2 = st; a2 = av; b2 = bv; ci2 = cv; end
    endcase
    rst_n    = rv;
    accepted = 0;
    if (!rv) begin
      kill_edge = e;
      next_free = e + 1;
    end else if (st && e >= next_free) begin
      q.push_back(ref_add(e, w, av, bv, cv));
      acc_edge  = e;
      next_free = e + n + 2;
      accepted  = 1;
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv);
    int tries;
    tries = 0;
    do begin
      drive(1'b1, av, bv, cv, 1'b1);
      tries++;
    end while (!accepted && tries < 20);
    chk("start_accepted", {7'b0, accepted}, 8'd1);
  endtask

  // Random start pulses and operand churn; anything issued during RUN/DONE must be ignored.
  task automatic churn(input int cycles);
    repeat (cycles) drive(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
  endtask

  task automatic switch_dut(input int s);
    sel       = s;
    acc_edge  = -1;
    next_free = 0;
    hs        = 8'h00;
    hc        = 1'b0;
    hv        = 1'b0;
  endtask

  initial begin
    int live_left;
    rst_n = 1'b0;
    {st0, st1, st2, ci0, ci1, ci2} = '0;
    {a0, b0, a2, b2} = '0;
    {a1, b1} = '0;
    repeat (3) drive(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    mon_en = 1;

    switch_dut(0);
    idle(2);
    issue(8'h5A, 8'h3C, 1'b0);
    idle(10);
    issue(8'hFF, 8'h01, 1'b0);
    idle(10);
    issue(8'hFF, 8'hFF, 1'b1);
    churn(6);
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom), 8'($urandom), 1'($urandom));
      churn(9);
    end
    idle(12);
    issue(8'h7F, 8'h01, 1'b0);
    idle(3);
    drive(1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
    idle(2);
    issue(8'h7F, 8'h01, 1'b0);
    idle(12);

    switch_dut(1);
    for (int x = 0; x < 512; x++) begin
      issue(8'(x & 15), 8'((x >> 4) & 15), 1'((x >> 8) & 1));
    end
    idle(6);

    switch_dut(2);
    repeat (40) drive(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    idle(8);

    live_left = 0;
    foreach (q[i]) if (q[i].cap >= kill_edge) live_left++;
    chk("pending_results", 8'(live_left), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required completion before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
